// File: rtl/rle_capture_wr.sv
// Run-length capture engine driving the write port (a_*) of the dual-clock 1Kx36 capture RAM.
// Define RLE_COMPRESS_EN for run-length compression; the default build stores every sample raw.
module rle_capture_wr #(
  parameter int DEPTH_LEN  = 1024,
  parameter int DEPTH_BITS = 10,
  parameter int DATA_BITS  = 32,
  parameter int RLE_BITS   = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          arm_i,
  input  logic                          sample_en_i,
  input  logic [DATA_BITS-1:0]          din_i,
  input  logic                          trigger_i,
  input  logic [DEPTH_BITS-1:0]         post_len_i,
  output logic                          a_en_o,
  output logic                          a_we_o,
  output logic [DEPTH_BITS-1:0]         a_addr_o,
  output logic [RLE_BITS+DATA_BITS-1:0] a_di_o,
  output logic                          armed_o,
  output logic                          done_o,
  output logic                          wrapped_o,
  output logic [DEPTH_BITS-1:0]         trig_addr_o
);

  localparam logic [DEPTH_BITS-1:0] ADDR_LAST = DEPTH_BITS'(DEPTH_LEN - 1);
  localparam logic [DEPTH_BITS-1:0] ONE       = DEPTH_BITS'(1);

  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

  state_t state_q, state_d;

  logic                          capturing;
  logic                          sampleQual;
  logic                          trigQual;
  logic                          doWrite;
  logic                          finishNow;
  logic [DEPTH_BITS-1:0]         postLenEff;
  logic [DEPTH_BITS-1:0]         postCntLoad;
  logic [DEPTH_BITS-1:0]         writeAddr;
  logic [DEPTH_BITS-1:0]         trigAddrNew;
  logic [RLE_BITS+DATA_BITS-1:0] wordDi;

  logic                          aEn_q;
  logic                          aWe_q, aWe_d;
  logic [DEPTH_BITS-1:0]         aAddr_q, aAddr_d;
  logic [RLE_BITS+DATA_BITS-1:0] aDi_q, aDi_d;
  logic                          armed_q, armed_d;
  logic                          done_q, done_d;
  logic                          wrapped_q, wrapped_d;
  logic [DEPTH_BITS-1:0]         trigAddr_q, trigAddr_d;
  logic [DEPTH_BITS-1:0]         postCnt_q, postCnt_d;
  logic                          lastWrite_q, lastWrite_d;

  function automatic logic [DEPTH_BITS-1:0] incAddr(input logic [DEPTH_BITS-1:0] addr);
    return (addr == ADDR_LAST) ? '0 : addr + ONE;
  endfunction

  // A pending write still owns a_addr_q, so a write issued now lands one slot further on.
  assign capturing  = (state_q == ARMED) || (state_q == POST);
  assign sampleQual = sample_en_i && capturing && !arm_i;
  assign trigQual   = sampleQual && trigger_i && (state_q == ARMED);
  assign postLenEff = (post_len_i == '0) ? ONE : post_len_i;
  assign writeAddr  = aWe_q ? incAddr(aAddr_q) : aAddr_q;

`ifdef RLE_COMPRESS_EN
  localparam logic [RLE_BITS-1:0] CNT_MAX = '1;

  logic                 holdValid_q, holdValid_d;
  logic [DATA_BITS-1:0] holdData_q, holdData_d;
  logic [RLE_BITS-1:0]  holdCnt_q, holdCnt_d;

  always_comb begin
    doWrite     = 1'b0;
    holdValid_d = holdValid_q;
    holdData_d  = holdData_q;
    holdCnt_d   = holdCnt_q;
    if (arm_i) begin
      holdValid_d = 1'b0;
      holdCnt_d   = '0;
    end else if (sampleQual) begin
      if (!holdValid_q) begin
        holdValid_d = 1'b1;
        holdData_d  = din_i;
        holdCnt_d   = '0;
      end else if ((din_i == holdData_q) && (holdCnt_q != CNT_MAX) && !trigQual) begin
        holdCnt_d = holdCnt_q + RLE_BITS'(1);
      end else begin
        doWrite    = 1'b1;
        holdData_d = din_i;
        holdCnt_d  = '0;
      end
      // The partial run left over after the final post-trigger word is dropped.
      if (doWrite && (state_q == POST) && (postCnt_q == ONE)) begin
        holdValid_d = 1'b0;
      end
    end
    wordDi      = {holdCnt_q, holdData_q};
    trigAddrNew = doWrite ? incAddr(writeAddr) : writeAddr;
  end

  assign finishNow   = doWrite && (state_q == POST) && (postCnt_q == ONE);
  assign postCntLoad = postLenEff;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      holdValid_q <= 1'b0;
      holdData_q  <= '0;
      holdCnt_q   <= '0;
    end else begin
      holdValid_q <= holdValid_d;
      holdData_q  <= holdData_d;
      holdCnt_q   <= holdCnt_d;
    end
  end
`else
  // Raw mode: the trigger sample is itself the first post-trigger word.
  always_comb begin
    doWrite     = sampleQual;
    wordDi      = {{RLE_BITS{1'b0}}, din_i};
    trigAddrNew = writeAddr;
  end

  assign finishNow   = doWrite && (((state_q == POST) && (postCnt_q == ONE)) ||
                                   (trigQual && (postLenEff == ONE)));
  assign postCntLoad = postLenEff - ONE;
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (arm_i) begin
      state_d = ARMED;
    end else begin
      case (state_q)
        ARMED: begin
          if (finishNow) begin
            state_d = DONE;
          end else if (trigQual) begin
            state_d = POST;
          end
        end
        POST: begin
          if (finishNow) begin
            state_d = DONE;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    aWe_d       = doWrite;
    aDi_d       = doWrite ? wordDi : aDi_q;
    aAddr_d     = aWe_q ? incAddr(aAddr_q) : aAddr_q;
    wrapped_d   = wrapped_q || (aWe_q && (aAddr_q == ADDR_LAST));
    trigAddr_d  = trigQual ? trigAddrNew : trigAddr_q;
    lastWrite_d = finishNow;
    armed_d     = armed_q;
    done_d      = done_q;
    postCnt_d   = postCnt_q;
    if (trigQual) begin
      postCnt_d = postCntLoad;
    end else if (doWrite && (state_q == POST)) begin
      postCnt_d = postCnt_q - ONE;
    end
    if (lastWrite_q) begin
      armed_d = 1'b0;
      done_d  = 1'b1;
    end
    if (arm_i) begin
      aAddr_d   = '0;
      wrapped_d = 1'b0;
      armed_d   = 1'b1;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      aEn_q       <= 1'b0;
      aWe_q       <= 1'b0;
      aAddr_q     <= '0;
      aDi_q       <= '0;
      armed_q     <= 1'b0;
      done_q      <= 1'b0;
      wrapped_q   <= 1'b0;
      trigAddr_q  <= '0;
      postCnt_q   <= '0;
      lastWrite_q <= 1'b0;
    end else begin
      aEn_q       <= 1'b1;
      aWe_q       <= aWe_d;
      aAddr_q     <= aAddr_d;
      aDi_q       <= aDi_d;
      armed_q     <= armed_d;
      done_q      <= done_d;
      wrapped_q   <= wrapped_d;
      trigAddr_q  <= trigAddr_d;
      postCnt_q   <= postCnt_d;
      lastWrite_q <= lastWrite_d;
    end
  end

  assign a_en_o      = aEn_q;
  assign a_we_o      = aWe_q;
  assign a_addr_o    = aAddr_q;
  assign a_di_o      = aDi_q;
  assign armed_o     = armed_q;
  assign done_o      = done_q;
  assign wrapped_o   = wrapped_q;
  assign trig_addr_o = trigAddr_q;

endmodule
